id_stage_pipe: RTL and testbench

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

---
 rtl/id_stage_pipe.sv | 150 +++++++++++++++
 tb/tb_id_stage_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// ID/EXE pipeline register with RAW hazard detection, valid/ready handshake and
// a saturating count of hazard-stall cycles.
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CMD_W  = 4,
    parameter int FW_EN  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              uses_src2,
    input  logic [REG_AW-1:0] dest,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] reg2,
    input  logic [CMD_W-1:0]  exe_cmd,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              wb_en,
    input  logic              is_immediate,
    input  logic              br_taken,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [REG_AW-1:0] out_dest,
    output logic [REG_AW-1:0] out_src1,
    output logic [REG_AW-1:0] out_src2,
    output logic [DATA_W-1:0] out_val1,
    output logic [DATA_W-1:0] out_val2,
    output logic [DATA_W-1:0] out_reg2,
    output logic [CMD_W-1:0]  out_exe_cmd,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic              out_wb_en,
    output logic              out_is_immediate,
    output logic              out_br_taken,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] reg2;
        logic [CMD_W-1:0]  exe_cmd;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              wb_en;
        logic              is_immediate;
        logic              br_taken;
    } payload_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    payload_t           pay_in, pay_d, pay_q;
    logic               valid_d, valid_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic               hazard;
    logic               xfer;

    // Register 0 is hardwired, so a writer targeting it never creates a dependency.
    function automatic logic hit(input logic [REG_AW-1:0] d, input logic w);
        return w && (d != '0) && ((d == src1) || (uses_src2 && (d == src2)));
    endfunction

    always_comb begin
        hazard = 1'b0;
        if (FW_EN != 0) hazard = in_valid & exe_mem_r_en & hit(exe_dest, exe_wb_en);
        else            hazard = in_valid & (hit(exe_dest, exe_wb_en) | hit(mem_dest, mem_wb_en));
    end

    assign in_ready = ~hazard & (~valid_q | out_ready);
    assign xfer     = in_valid & in_ready & ~flush;

    always_comb begin
        pay_in.dest         = dest;
        pay_in.src1         = src1;
        pay_in.src2         = src2;
        pay_in.val1         = val1;
        pay_in.val2         = val2;
        pay_in.reg2         = reg2;
        pay_in.exe_cmd      = exe_cmd;
        pay_in.mem_r_en     = mem_r_en;
        pay_in.mem_w_en     = mem_w_en;
        pay_in.wb_en        = wb_en;
        pay_in.is_immediate = is_immediate;
        pay_in.br_taken     = br_taken;
    end

    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        cnt_d   = cnt_q;
        if (hazard && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
        if (!(valid_q && !out_ready)) begin
            if (xfer) begin
                valid_d = 1'b1;
                pay_d   = pay_in;
            end else begin
                // A bubble keeps its data but must not write, access memory or redirect.
                valid_d        = 1'b0;
                pay_d.wb_en    = 1'b0;
                pay_d.mem_r_en = 1'b0;
                pay_d.mem_w_en = 1'b0;
                pay_d.br_taken = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid        = valid_q;
    assign out_dest         = pay_q.dest;
    assign out_src1         = pay_q.src1;
    assign out_src2         = pay_q.src2;
    assign out_val1         = pay_q.val1;
    assign out_val2         = pay_q.val2;
    assign out_reg2         = pay_q.reg2;
    assign out_exe_cmd      = pay_q.exe_cmd;
    assign out_mem_r_en     = pay_q.mem_r_en;
    assign out_mem_w_en     = pay_q.mem_w_en;
    assign out_wb_en        = pay_q.wb_en;
    assign out_is_immediate = pay_q.is_immediate;
    assign out_br_taken     = pay_q.br_taken;
    assign stall_cnt        = cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: three instances (forwarding, no forwarding, 2-bit counter)
// share one stimulus and are compared against a behavioural model of the stage.
module tb_id_stage_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, uses_src2, mem_r_en, mem_w_en, wb_en, is_immediate, br_taken;
    logic [4:0]  src1, src2, dest, exe_dest, mem_dest;
    logic [31:0] val1, val2, reg2;
    logic [3:0]  exe_cmd;
    logic        exe_wb_en, exe_mem_r_en, mem_wb_en, flush, out_ready;

    logic        o_rdy[3], o_valid[3], o_mr[3], o_mw[3], o_wb[3], o_imm[3], o_br[3];
    logic [4:0]  o_dest[3], o_src1[3], o_src2[3];
    logic [31:0] o_val1[3], o_val2[3], o_reg2[3];
    logic [3:0]  o_cmd[3];
    logic [15:0] cnt_w[3];
    logic [120:0] obs[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CW = (g == 2) ? 2 : 16;
        logic [CW-1:0] cnt;
        id_stage_pipe #(.FW_EN((g == 1) ? 0 : 1), .CNT_W(CW)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[g]),
            .src1(src1), .src2(src2), .uses_src2(uses_src2), .dest(dest),
            .val1(val1), .val2(val2), .reg2(reg2), .exe_cmd(exe_cmd),
            .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
            .is_immediate(is_immediate), .br_taken(br_taken),
            .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
            .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .flush(flush), .out_ready(out_ready),
            .out_valid(o_valid[g]), .out_dest(o_dest[g]), .out_src1(o_src1[g]),
            .out_src2(o_src2[g]), .out_val1(o_val1[g]), .out_val2(o_val2[g]),
            .out_reg2(o_reg2[g]), .out_exe_cmd(o_cmd[g]), .out_mem_r_en(o_mr[g]),
            .out_mem_w_en(o_mw[g]), .out_wb_en(o_wb[g]), .out_is_immediate(o_imm[g]),
            .out_br_taken(o_br[g]), .stall_cnt(cnt)
        );
        assign cnt_w[g] = 16'(cnt);
        assign obs[g] = {o_valid[g], o_dest[g], o_src1[g], o_src2[g], o_val1[g], o_val2[g],
                         o_reg2[g], o_cmd[g], o_mr[g], o_mw[g], o_wb[g], o_imm[g], o_br[g]};
    end

    // Behavioural model: what the EXE stage should currently see from each instance.
    typedef struct {
        bit          v;
        logic [4:0]  dest, src1, src2;
        logic [31:0] val1, val2, reg2;
        logic [3:0]  cmd;
        bit          mr, mw, wb, imm, br;
        int          cnt;
    } mdl_t;

    mdl_t m[3];
    int total = 0;
    int bad   = 0;

    function automatic bit reads(input logic [4:0] r, input logic w);
        return w && (r != 0) && ((r == src1) || (uses_src2 && (r == src2)));
    endfunction

    function automatic bit exp_haz(input int i);
        if (!in_valid) return 0;
        if (i != 1) return exe_mem_r_en && reads(exe_dest, exe_wb_en);
        return reads(exe_dest, exe_wb_en) || reads(mem_dest, mem_wb_en);
    endfunction

    function automatic bit exp_rdy(input int i);
        return !exp_haz(i) && (!m[i].v || out_ready);
    endfunction

    function automatic mdl_t model_next(input int i);
        mdl_t n = m[i];
        int cmax = (i == 2) ? 3 : 65535;
        if (exp_haz(i) && n.cnt < cmax) n.cnt = n.cnt + 1;
        if (m[i].v && !out_ready) return n;
        if (in_valid && exp_rdy(i) && !flush) begin
            n.v = 1; n.dest = dest; n.src1 = src1; n.src2 = src2;
            n.val1 = val1; n.val2 = val2; n.reg2 = reg2; n.cmd = exe_cmd;
            n.mr = mem_r_en; n.mw = mem_w_en; n.wb = wb_en; n.imm = is_immediate; n.br = br_taken;
        end else begin
            n.v = 0; n.mr = 0; n.mw = 0; n.wb = 0; n.br = 0;
        end
        return n;
    endfunction

    function automatic logic [120:0] pack(input mdl_t x);
        return {x.v, x.dest, x.src1, x.src2, x.val1, x.val2, x.reg2, x.cmd,
                x.mr, x.mw, x.wb, x.imm, x.br};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m[i] = '{default: 0};
    endtask

    task automatic tick();
        mdl_t n[3];
        for (int i = 0; i < 3; i++) n[i] = model_next(i);
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; uses_src2 = 0; src1 = 0; src2 = 0; dest = 0;
        val1 = 0; val2 = 0; reg2 = 0; exe_cmd = 0;
        mem_r_en = 0; mem_w_en = 0; wb_en = 0; is_immediate = 0; br_taken = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic rand_inputs();
        in_valid = 1'($urandom); uses_src2 = 1'($urandom);
        src1 = 5'($urandom_range(0, 3)); src2 = 5'($urandom_range(0, 3));
        dest = 5'($urandom_range(0, 31));
        val1 = $urandom; val2 = $urandom; reg2 = $urandom; exe_cmd = 4'($urandom);
        mem_r_en = 1'($urandom); mem_w_en = 1'($urandom); wb_en = 1'($urandom);
        is_immediate = 1'($urandom); br_taken = 1'($urandom);
        exe_dest = 5'($urandom_range(0, 3)); exe_wb_en = 1'($urandom); exe_mem_r_en = 1'($urandom);
        mem_dest = 5'($urandom_range(0, 3)); mem_wb_en = 1'($urandom);
        flush = ($urandom_range(0, 7) == 0); out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic test_reset();
        clear_inputs();
        in_valid = 1; src1 = 1;
        rst = 0; model_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs[i] !== '0 || cnt_w[i] !== 16'd0) begin
                bad++; $display("FAIL reset_state inst=%0d got=%h cnt=%0d want all zero", i, obs[i], cnt_w[i]);
            end
            total++;
            if (o_rdy[i] !== 1'b1) begin
                bad++; $display("FAIL reset_in_ready inst=%0d got=%b want 1", i, o_rdy[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1;
        clear_inputs();
    endtask

    task automatic test_plain();
        clear_inputs();
        in_valid = 1; dest = 3; val1 = 32'h10; wb_en = 1;
        tick();
        clear_inputs();
        total++;
        if ({o_valid[0], o_dest[0], o_val1[0], o_wb[0]} !== {1'b1, 5'd3, 32'h10, 1'b1}) begin
            bad++; $display("FAIL plain_flow got v=%b d=%0d v1=%h wb=%b want v=1 d=3 v1=10 wb=1",
                            o_valid[0], o_dest[0], o_val1[0], o_wb[0]);
        end
        tick();
        total++;
        if (o_valid[0] !== 1'b0 || o_wb[0] !== 1'b0) begin
            bad++; $display("FAIL plain_bubble got v=%b wb=%b want 0 0", o_valid[0], o_wb[0]);
        end
    endtask

    task automatic test_load_use();
        int c0;
        clear_inputs();
        c0 = m[0].cnt;
        in_valid = 1; src1 = 5; dest = 9; wb_en = 1; val1 = 32'hAB;
        exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 5;
        #1;
        total++;
        if (o_rdy[0] !== 1'b0) begin
            bad++; $display("FAIL load_use_ready got=%b want 0", o_rdy[0]);
        end
        tick();
        total++;
        if (o_valid[0] !== 1'b0 || cnt_w[0] !== 16'(c0 + 1)) begin
            bad++; $display("FAIL load_use_stall got v=%b cnt=%0d want v=0 cnt=%0d", o_valid[0], cnt_w[0], c0 + 1);
        end
        exe_mem_r_en = 0;
        #1;
        total++;
        if (o_rdy[0] !== 1'b1) begin
            bad++; $display("FAIL load_use_release_ready got=%b want 1", o_rdy[0]);
        end
        tick();
        total++;
        if (o_valid[0] !== 1'b1 || o_dest[0] !== 5'd9 || o_val1[0] !== 32'hAB) begin
            bad++; $display("FAIL load_use_accept got v=%b d=%0d v1=%h want v=1 d=9 v1=ab", o_valid[0], o_dest[0], o_val1[0]);
        end
        total++;
        if (o_valid[1] !== 1'b0) begin
            bad++; $display("FAIL nofw_exe_raw got v=%b want 0", o_valid[1]);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_no_forward();
        clear_inputs();
        in_valid = 1; src1 = 2; src2 = 7; uses_src2 = 1; mem_wb_en = 1; mem_dest = 7;
        #1;
        total++;
        if (o_rdy[1] !== 1'b0 || o_rdy[0] !== 1'b1) begin
            bad++; $display("FAIL nofw_src2_stall got nofw=%b fw=%b want 0 1", o_rdy[1], o_rdy[0]);
        end
        uses_src2 = 0;
        #1;
        total++;
        if (o_rdy[1] !== 1'b1) begin
            bad++; $display("FAIL nofw_no_src2 got=%b want 1", o_rdy[1]);
        end
        uses_src2 = 1; src1 = 0; src2 = 0; mem_dest = 0; exe_dest = 0; exe_wb_en = 1; exe_mem_r_en = 1;
        #1;
        total++;
        if (o_rdy[1] !== 1'b1 || o_rdy[0] !== 1'b1) begin
            bad++; $display("FAIL reg0_no_hazard got nofw=%b fw=%b want 1 1", o_rdy[1], o_rdy[0]);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_backpressure();
        logic [120:0] snap;
        clear_inputs();
        in_valid = 1; dest = 4; val1 = 32'h1234; wb_en = 1;
        tick();
        snap = obs[0];
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            out_ready = 0;
            #1;
            total++;
            if (o_rdy[0] !== 1'b0) begin
                bad++; $display("FAIL bp_ready cyc=%0d got=%b want 0", k, o_rdy[0]);
            end
            tick();
            total++;
            if (obs[0] !== snap) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%h want %h", k, obs[0], snap);
            end
        end
        clear_inputs();
        in_valid = 1; dest = 6; val1 = 32'h5678;
        tick();
        total++;
        if (o_valid[0] !== 1'b1 || o_dest[0] !== 5'd6 || o_val1[0] !== 32'h5678) begin
            bad++; $display("FAIL bp_release got v=%b d=%0d v1=%h want v=1 d=6 v1=5678", o_valid[0], o_dest[0], o_val1[0]);
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        in_valid = 1; flush = 1; br_taken = 1; wb_en = 1; mem_w_en = 1; dest = 8;
        tick();
        total++;
        if (o_valid[0] !== 1'b0 || o_wb[0] !== 1'b0 || o_br[0] !== 1'b0 || o_mw[0] !== 1'b0) begin
            bad++; $display("FAIL flush got v=%b wb=%b br=%b mw=%b want all 0", o_valid[0], o_wb[0], o_br[0], o_mw[0]);
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        int want[6] = '{1, 2, 3, 3, 3, 3};
        clear_inputs();
        rst = 0; model_reset(); #2; rst = 1;
        in_valid = 1; src1 = 5; exe_dest = 5; exe_wb_en = 1; exe_mem_r_en = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (cnt_w[2] !== 16'(want[k])) begin
                bad++; $display("FAIL saturate cyc=%0d got=%0d want %0d", k, cnt_w[2], want[k]);
            end
        end
        exe_mem_r_en = 0; dest = 2; wb_en = 1;
        tick();
        #3;
        rst = 0; model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs[i] !== '0 || cnt_w[i] !== 16'd0) begin
                bad++; $display("FAIL async_reset inst=%0d got=%h cnt=%0d want all zero", i, obs[i], cnt_w[i]);
            end
        end
        rst = 1;
        clear_inputs();
    endtask

    task automatic test_reset_mid_bp();
        clear_inputs();
        in_valid = 1; dest = 11; wb_en = 1;
        tick();
        out_ready = 0; dest = 12; val1 = 32'hBEEF;
        #2;
        rst = 0; model_reset();
        #1;
        rst = 1;
        #1;
        total++;
        if (o_rdy[0] !== 1'b1 || o_valid[0] !== 1'b0) begin
            bad++; $display("FAIL rst_bp_empty got rdy=%b v=%b want 1 0", o_rdy[0], o_valid[0]);
        end
        tick();
        total++;
        if (o_valid[0] !== 1'b1 || o_dest[0] !== 5'd12 || o_val1[0] !== 32'hBEEF) begin
            bad++; $display("FAIL rst_bp_load got v=%b d=%0d v1=%h want v=1 d=12 v1=beef", o_valid[0], o_dest[0], o_val1[0]);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rand_inputs();
            #1;
            for (int i = 0; i < 3; i++) begin
                total++;
                if (o_rdy[i] !== exp_rdy(i)) begin
                    bad++; $display("FAIL rand_ready cyc=%0d inst=%0d got=%b want %b", k, i, o_rdy[i], exp_rdy(i));
                end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obs[i] !== pack(m[i]) || cnt_w[i] !== 16'(m[i].cnt)) begin
                    bad++; $display("FAIL rand_out cyc=%0d inst=%0d got=%h cnt=%0d want %h cnt=%0d",
                                    k, i, obs[i], cnt_w[i], pack(m[i]), m[i].cnt);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_plain();
        test_load_use();
        test_no_forward();
        test_backpressure();
        test_flush();
        test_saturation();
        test_reset_mid_bp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
